// File: rtl/stream_mux_n_if.sv
// Stream bundle for stream_mux_n: per-channel producer side, one consumer side, and select controls.
interface stream_mux_n_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 8
);
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                    mode;
    logic [CW-1:0]           sel;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [CW-1:0]           out_ch;
    logic                    out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_n.sv
// N:1 valid/ready stream multiplexer with manual or round-robin selection and a registered output stage.
module stream_mux_n #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 8
) (
    input logic          clk,
    input logic          rst_n,
    stream_mux_n_if.slave bus
);
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    ch_q, ch_d;
    logic [CW-1:0]    rr_ptr_q, rr_ptr_d;

    logic             load_en;
    logic [CW-1:0]    gnt;
    logic             gnt_valid;
    logic [CW-1:0]    rr_idx;
    logic [WIDTH-1:0] gnt_data;

    // Grant: manual select (out-of-range sel grants nothing) or first valid scanning from rr_ptr.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        rr_idx    = '0;
        if (!bus.mode) begin
            if (32'(bus.sel) < NUM_CH) begin
                gnt       = bus.sel;
                gnt_valid = bus.in_valid[bus.sel];
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                rr_idx = CW'((32'(rr_ptr_q) + k) % NUM_CH);
                if (!gnt_valid && bus.in_valid[rr_idx]) begin
                    gnt       = rr_idx;
                    gnt_valid = 1'b1;
                end
            end
        end
        gnt_data = bus.in_data[32'(gnt) * WIDTH +: WIDTH];
    end

    assign load_en = (state_q == ST_EMPTY) || bus.out_ready;

    // Ready is one-hot on the granted channel, forced low while reset is asserted.
    always_comb begin
        bus.in_ready = '0;
        if (rst_n && load_en && gnt_valid) begin
            bus.in_ready[gnt] = 1'b1;
        end
    end

    // Output-stage next state: load on grant, drain to empty otherwise, hold under backpressure.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        ch_d     = ch_q;
        rr_ptr_d = rr_ptr_q;
        if (load_en) begin
            if (gnt_valid) begin
                state_d = ST_FULL;
                data_d  = gnt_data;
                ch_d    = gnt;
                if (bus.mode) begin
                    rr_ptr_d = (32'(gnt) == NUM_CH - 1) ? '0 : gnt + CW'(1);
                end
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            data_q   <= '0;
            ch_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            ch_q     <= ch_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;

endmodule
